// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the FSM state encoding and the guard counter sizing helper.
// No logic of its own; imported by uart_tx_scheduler.
package uart_tx_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_t;

  // Guard counter must hold the value BUSY_WAIT-1; one spare bit keeps
  // BUSY_WAIT == 1 (clog2 == 0) at a legal non-zero width.
  function automatic int guard_width(input int busy_wait);
    return $clog2(busy_wait) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose : small synchronous byte FIFO feeding the UART transmit scheduler.
// Latency : write visible in count one cycle after push; head is combinational
//           (no read latency), pop advances on the clock edge.
// Backpr. : push while full is ignored (caller flags overflow); pop while empty
//           is ignored; flush discards everything and beats push/pop.
// Ports   : clk, reset (async active-low), push/push_data, pop, flush,
//           head, count, full, empty.
module uart_tx_fifo #(
  parameter int WIDTH_D    = 8,
  parameter int DEPTH_FIFO = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH_D-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [WIDTH_D-1:0] head,
  output logic [DEPTH_FIFO:0] count,
  output logic               full,
  output logic               empty
);

  localparam int ENTRIES = 1 << DEPTH_FIFO;

  logic [WIDTH_D-1:0]    mem [ENTRIES];
  logic [DEPTH_FIFO-1:0] wr_ptr;
  logic [DEPTH_FIFO-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO drops the push even if a pop frees a slot this same cycle;
  // that keeps the drop decision a pure function of the registered count.
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  assign full  = (count == (DEPTH_FIFO+1)'(ENTRIES));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers roll over naturally; count is one bit wider so that full and
  // empty stay distinguishable when the pointers are equal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose : queues CPU UART writes and hands them to uart_io one at a time.
// Latency : byte pushed into an empty FIFO at edge N (uart_busy low) is popped
//           at N+1 and tx_we is high for the single cycle that follows.
// Backpr. : waits for uart_busy low before each pop and for the busy pulse to
//           finish after each strobe; pushes into a full FIFO are dropped and
//           latched in the sticky overflow flag.
// Ports   : clk, reset (async active-low); CPU side wr_data/wr_we, flush,
//           clr_overflow; uart side uart_busy, tx_data, tx_we; status
//           fifo_count, fifo_full, fifo_empty, overflow, sched_busy.
module uart_tx_scheduler #(
  parameter int WIDTH_D    = 8,
  parameter int DEPTH_FIFO = 2,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH_D-1:0]  wr_data,
  input  logic                wr_we,
  input  logic                flush,
  input  logic                clr_overflow,
  input  logic                uart_busy,
  output logic [WIDTH_D-1:0]  tx_data,
  output logic                tx_we,
  output logic [DEPTH_FIFO:0] fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output logic                sched_busy
);

  import uart_tx_sched_pkg::*;

  localparam int                 GUARD_W    = guard_width(BUSY_WAIT);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(BUSY_WAIT - 1);

  state_t               state;
  state_t               state_next;
  logic [GUARD_W-1:0]   guard;
  logic                 pop;
  logic                 drop_evt;
  logic [WIDTH_D-1:0]   head;

  uart_tx_fifo #(
    .WIDTH_D    (WIDTH_D),
    .DEPTH_FIFO (DEPTH_FIFO)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_we),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A push discarded by flush is not an overflow: the queue is being
  // emptied on purpose.
  assign drop_evt   = wr_we && fifo_full && !flush;
  assign sched_busy = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !uart_busy) begin
          pop        = 1'b1;
          state_next = STROBE;
        end
      end
      STROBE: begin
        state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        // The guard lets the FSM move on when busy never rises, e.g. a
        // pulse too short to be seen or a uart_io that is already done.
        if (uart_busy || (guard == GUARD_LAST)) begin
          state_next = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (!uart_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Flush overrides everything; a byte already strobed stays sent, but
    // nothing further is popped.
    if (flush) begin
      state_next = IDLE;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_we   <= 1'b0;
      tx_data <= '0;
      guard   <= '0;
    end else begin
      state <= state_next;
      // Registered strobe: high exactly while the FSM sits in STROBE, which
      // lasts one cycle and is always followed by WAIT_RISE or IDLE.
      tx_we <= (state_next == STROBE);
      if (pop) begin
        tx_data <= head;
      end
      if (state == STROBE) begin
        guard <= '0;
      end else if ((state == WAIT_RISE) && (state_next == WAIT_RISE)) begin
        guard <= guard + 1'b1;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set so
  // the CPU cannot miss the newer loss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop_evt) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with hand-computed expectations.
// Strobes are logged on the falling edge; inputs change 1 time unit after
// the rising edge.
module tb_uart_tx_scheduler;

  localparam int WIDTH_D    = 8;
  localparam int DEPTH_FIFO = 2;
  localparam int BUSY_WAIT  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [WIDTH_D-1:0]  wr_data;
  logic                wr_we;
  logic                flush;
  logic                clr_overflow;
  logic                busy_direct;
  logic                model_en;
  logic                model_busy;
  wire                 uart_busy;
  logic [WIDTH_D-1:0]  tx_data;
  logic                tx_we;
  logic [DEPTH_FIFO:0] fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                overflow;
  logic                sched_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0] tx_log [$];
  int         tx_cyc [$];
  logic       prev_we = 1'b0;
  int         base;

  assign uart_busy = model_en ? model_busy : busy_direct;

  uart_tx_scheduler #(
    .WIDTH_D    (WIDTH_D),
    .DEPTH_FIFO (DEPTH_FIFO),
    .BUSY_WAIT  (BUSY_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_we        (wr_we),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .uart_busy    (uart_busy),
    .tx_data      (tx_data),
    .tx_we        (tx_we),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow),
    .sched_busy   (sched_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe logger; also confirms tx_we is never high two cycles running.
  always @(negedge clk) begin
    if (tx_we) begin
      check_eq("we_single_cycle", {31'd0, prev_we}, 32'd0);
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    prev_we = tx_we;
  end

  // uart_io stand-in: busy rises 2 cycles after a strobe and lasts 20 cycles.
  initial begin
    int dly;
    int hold;
    model_busy = 1'b0;
    dly  = 0;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!model_en) begin
        dly = 0;
        hold = 0;
        model_busy = 1'b0;
      end else begin
        if (tx_we) dly = 2;
        else if (dly > 0) begin
          dly--;
          if (dly == 0) hold = 20;
        end
        if (hold > 0) begin
          model_busy = 1'b1;
          hold--;
        end else begin
          model_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task push_byte(input logic [7:0] d);
    wr_data = d;
    wr_we   = 1'b1;
    step();
    wr_we   = 1'b0;
  endtask

  task wait_strobes(input string tag, input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && tx_log.size() < n; i++) step();
    check_eq(tag, tx_log.size(), n);
  endtask

  task wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && sched_busy; i++) step();
    check_eq(tag, {31'd0, sched_busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    wr_data      = '0;
    wr_we        = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    busy_direct  = 1'b0;
    model_en     = 1'b0;

    // Reset state
    #12;
    check_eq("rst_tx_we",   {31'd0, tx_we}, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_count",   fifo_count, 0);
    check_eq("rst_full",    {31'd0, fifo_full}, 0);
    check_eq("rst_empty",   {31'd0, fifo_empty}, 1);
    check_eq("rst_ovf",     {31'd0, overflow}, 0);
    check_eq("rst_sched",   {31'd0, sched_busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    step_n(2);

    // Single byte: strobe in the second cycle after the push edge
    push_byte(8'h41);
    check_eq("single_count1", fifo_count, 1);
    check_eq("single_we_early", {31'd0, tx_we}, 0);
    step();
    check_eq("single_we", {31'd0, tx_we}, 1);
    check_eq("single_data", tx_data, 8'h41);
    check_eq("single_count0", fifo_count, 0);
    step();
    check_eq("single_we_off", {31'd0, tx_we}, 0);
    busy_direct = 1'b1;
    step_n(2);
    check_eq("single_sched_hi", {31'd0, sched_busy}, 1);
    busy_direct = 1'b0;
    step();
    check_eq("single_sched_lo", {31'd0, sched_busy}, 0);

    // Burst of 4, held off by busy until full, then drained by the model
    busy_direct = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    check_eq("burst_full", {31'd0, fifo_full}, 1);
    check_eq("burst_count", fifo_count, 4);
    base = tx_log.size();
    model_en = 1'b1;
    wait_strobes("burst_strobes", base + 4, 300);
    for (int i = 0; i < 4; i++) begin
      check_eq("burst_data", tx_log[base+i], 32'(i + 1));
      if (i > 0) check_eq("burst_gap", tx_cyc[base+i] - tx_cyc[base+i-1], 24);
    end
    wait_idle("burst_idle", 100);
    busy_direct = 1'b0;
    model_en = 1'b0;
    step();

    // Busy guard: uart_busy never rises, 6 idle cycles between strobes
    base = tx_log.size();
    push_byte(8'hAA);
    push_byte(8'hBB);
    wait_strobes("guard_strobes", base + 2, 50);
    check_eq("guard_data0", tx_log[base], 8'hAA);
    check_eq("guard_data1", tx_log[base+1], 8'hBB);
    check_eq("guard_gap", tx_cyc[base+1] - tx_cyc[base] - 1, BUSY_WAIT + 2);
    wait_idle("guard_idle", 50);

    // Overflow
    busy_direct = 1'b1;
    base = tx_log.size();
    push_byte(8'h10);
    push_byte(8'h20);
    push_byte(8'h30);
    push_byte(8'h40);
    check_eq("ovf_full", {31'd0, fifo_full}, 1);
    check_eq("ovf_pre", {31'd0, overflow}, 0);
    push_byte(8'h55);
    check_eq("ovf_set", {31'd0, overflow}, 1);
    check_eq("ovf_count", fifo_count, 4);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_eq("ovf_clr", {31'd0, overflow}, 0);
    clr_overflow = 1'b1;
    push_byte(8'h66);
    clr_overflow = 1'b0;
    check_eq("ovf_set_wins", {31'd0, overflow}, 1);
    busy_direct = 1'b0;
    wait_strobes("ovf_strobes", base + 4, 100);
    check_eq("ovf_d0", tx_log[base],   8'h10);
    check_eq("ovf_d1", tx_log[base+1], 8'h20);
    check_eq("ovf_d2", tx_log[base+2], 8'h30);
    check_eq("ovf_d3", tx_log[base+3], 8'h40);
    wait_idle("ovf_idle", 50);
    check_eq("ovf_no_extra", tx_log.size(), base + 4);

    // Flush with a simultaneous push
    busy_direct = 1'b1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    check_eq("flush_pre_count", fifo_count, 3);
    flush   = 1'b1;
    push_byte(8'h77);
    flush   = 1'b0;
    check_eq("flush_count", fifo_count, 0);
    check_eq("flush_empty", {31'd0, fifo_empty}, 1);
    check_eq("flush_ovf_kept", {31'd0, overflow}, 1);
    check_eq("flush_txdata_kept", tx_data, 8'h40);
    base = tx_log.size();
    busy_direct = 1'b0;
    step_n(20);
    check_eq("flush_no_strobe", tx_log.size(), base);
    check_eq("flush_sched", {31'd0, sched_busy}, 0);

    // Async reset while in WAIT_FALL with 2 bytes queued
    push_byte(8'hC1);
    push_byte(8'hC2);
    wr_data = 8'hC3;
    wr_we   = 1'b1;
    step();
    wr_we   = 1'b0;
    busy_drect_set: begin
      busy_direct = 1'b1;
    end
    step();
    check_eq("ar_pre_count", fifo_count, 2);
    check_eq("ar_pre_sched", {31'd0, sched_busy}, 1);
    check_eq("ar_pre_data", tx_data, 8'hC1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_tx_data", tx_data, 0);
    check_eq("ar_tx_we",   {31'd0, tx_we}, 0);
    check_eq("ar_count",   fifo_count, 0);
    check_eq("ar_full",    {31'd0, fifo_full}, 0);
    check_eq("ar_empty",   {31'd0, fifo_empty}, 1);
    check_eq("ar_ovf",     {31'd0, overflow}, 0);
    check_eq("ar_sched",   {31'd0, sched_busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    busy_direct = 1'b0;
    base = tx_log.size();
    step_n(20);
    check_eq("ar_no_strobe", tx_log.size(), base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
